angle_tracker: RTL and testbench

Second-generation rotor angle generator for the LitSpin LED controller. It measures the rotation period from the once-per-turn `turn_tick` sensor pulse, divides each turn into `NB_ANGLES` equal slots, and outputs the current slot index to the column/frame fetch logic. Compared with the first-generation angle computer, it adds:
- an input synchroniser;
- glitch rejection;
- lock and stall detection;
- a programmable angle offset and reverse-rotation mode;
- strobes for angle change and turn start.

---
 rtl/angle_tracker.sv | 219 +++++++++++++++++++++
 tb/tb_angle_tracker.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/angle_tracker.sv
// -----------------------------------------------------------------------------
// angle_tracker
//
// Rotor angle generator for the LED controller. It measures the rotation period
// from the once-per-turn turn_tick sensor pulse and divides each turn into
// NB_ANGLES equal slots. The current slot index goes to the column/frame fetch
// logic.
//
// Pipeline overview:
//   turn_tick -> synchroniser -> rising-edge detect -> acceptance filter
//   acceptance -> cycle counter / FSM / period register
//   period -> slot length -> slot counter -> raw angle -> offset/reverse -> angle
//
// Behaviour notes:
//   - A tick event is accepted only once the cycle counter has reached
//     MIN_PERIOD, or while the FSM is UNLOCKED. This filter drops sensor
//     glitches.
//   - Each turn counts up to NB_ANGLES-1 and then holds there, which covers a
//     rotor that is slowing down. The next accepted tick restarts the count at
//     0, which skips any remaining slots when the rotor speeds up.
//   - If the cycle counter saturates, no tick has arrived for
//     2^COUNTER_WIDTH-1 cycles. The block then drops lock and flags stalled.
// -----------------------------------------------------------------------------
module angle_tracker #(
  parameter  int COUNTER_WIDTH = 32,
  parameter  int NB_ANGLES     = 128,
  parameter  int MIN_PERIOD    = 1024,
  parameter  int SYNC_STAGES   = 2,
  localparam int ANGLE_WIDTH   = $clog2(NB_ANGLES)
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     turn_tick,
  input  logic [ANGLE_WIDTH-1:0]   angle_offset,
  input  logic                     reverse,
  output logic [ANGLE_WIDTH-1:0]   angle,
  output logic                     angle_tick,
  output logic                     turn_start,
  output logic [COUNTER_WIDTH-1:0] period,
  output logic                     locked,
  output logic                     stalled
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (NB_ANGLES < 2 || (1 << ANGLE_WIDTH) != NB_ANGLES) begin : g_bad_nb_angles
    $error("angle_tracker: NB_ANGLES must be a power of two and at least 2");
  end

  if (MIN_PERIOD < NB_ANGLES) begin : g_bad_min_period
    $error("angle_tracker: MIN_PERIOD must be at least NB_ANGLES");
  end

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("angle_tracker: SYNC_STAGES must be at least 2");
  end

  if (COUNTER_WIDTH <= $clog2(MIN_PERIOD)) begin : g_bad_counter_width
    $error("angle_tracker: COUNTER_WIDTH must exceed clog2(MIN_PERIOD)");
  end

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_MEASURING = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE   = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] MIN_SPACE = COUNTER_WIDTH'(MIN_PERIOD);
  localparam logic [ANGLE_WIDTH-1:0]   RAW_MAX   = '1;
  localparam logic [ANGLE_WIDTH-1:0]   RAW_ONE   = ANGLE_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Internal signals
  // ---------------------------------------------------------------------------
  state_t                   state;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     tick_prev;
  logic                     tick_event;
  logic                     accept;
  logic [COUNTER_WIDTH-1:0] cyc_cnt;
  logic                     cnt_sat;
  logic [COUNTER_WIDTH-1:0] slot_len;
  logic [COUNTER_WIDTH-1:0] slot_cnt;
  logic [COUNTER_WIDTH-1:0] slot_nxt;
  logic                     slot_wrap;
  logic [ANGLE_WIDTH-1:0]   raw;
  logic [ANGLE_WIDTH-1:0]   raw_nxt;
  logic                     raw_inc;
  logic [ANGLE_WIDTH-1:0]   angle_nxt;

  // ---------------------------------------------------------------------------
  // Synchroniser chain and previous-value flop for rising-edge detection
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the values
  //       from before the edge, which makes the shift chain order-independent.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q    <= '0;
      tick_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], turn_tick};
      tick_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  // Tick event detection and the acceptance filter
  assign tick_event = sync_q[SYNC_STAGES-1] & ~tick_prev;
  assign cnt_sat    = (cyc_cnt == CNT_MAX);
  assign accept     = tick_event &&
                      ((cyc_cnt >= MIN_SPACE) || (state == ST_UNLOCKED));

  // ---------------------------------------------------------------------------
  // Cycle counter: a saturating count of cycles since the last accepted tick.
  // It is loaded with 1 on acceptance, so it holds the exact spacing when the
  // next tick arrives.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cyc_cnt <= '0;
    end else if (accept) begin
      cyc_cnt <= CNT_ONE;
    end else if (!cnt_sat) begin
      cyc_cnt <= cyc_cnt + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot length: the floor division of the period. The remainder cycles are
  // absorbed into the last slot, because raw holds at NB_ANGLES-1 until the
  // next tick.
  // ---------------------------------------------------------------------------
  assign slot_len  = period >> ANGLE_WIDTH;
  assign slot_wrap = (slot_cnt == slot_len - CNT_ONE);

  // Next raw angle and slot counter. A tick has priority over a slot wrap or
  // over counter saturation.
  // NOTE: every signal driven here gets a default first, so no path leaves it
  //       unassigned and no latch can be inferred.
  always_comb begin
    raw_nxt  = raw;
    slot_nxt = slot_cnt;
    raw_inc  = 1'b0;
    if (accept) begin
      raw_nxt  = '0;
      slot_nxt = '0;
    end else if (state == ST_LOCKED && !cnt_sat) begin
      if (slot_wrap) begin
        slot_nxt = '0;
        if (raw != RAW_MAX) begin
          raw_nxt = raw + RAW_ONE;
          raw_inc = 1'b1;
        end
      end else begin
        slot_nxt = slot_cnt + CNT_ONE;
      end
    end else begin
      // Unlocked, measuring, or about to drop lock: hold angle 0.
      raw_nxt  = '0;
      slot_nxt = '0;
    end
  end

  // Output angle mapping. In reverse mode the slot index is mirrored
  // (NB_ANGLES-1-raw is a bitwise invert for a power-of-two count). The offset
  // is then added modulo NB_ANGLES by natural truncation.
  assign angle_nxt = (reverse ? ~raw_nxt : raw_nxt) + angle_offset;

  // ---------------------------------------------------------------------------
  // Tracking FSM, together with the period/lock/stall flags, the raw angle
  // state and the registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ST_UNLOCKED;
      period     <= '0;
      locked     <= 1'b0;
      stalled    <= 1'b0;
      turn_start <= 1'b0;
      angle_tick <= 1'b0;
      raw        <= '0;
      slot_cnt   <= '0;
      angle      <= '0;
    end else begin
      turn_start <= accept;
      angle_tick <= accept | raw_inc;
      raw        <= raw_nxt;
      slot_cnt   <= slot_nxt;
      angle      <= angle_nxt;

      if (accept) begin
        stalled <= 1'b0;
        case (state)
          ST_UNLOCKED: begin
            state <= ST_MEASURING;
          end
          ST_MEASURING, ST_LOCKED: begin
            state  <= ST_LOCKED;
            period <= cyc_cnt;
            locked <= 1'b1;
          end
          default: begin
            state <= ST_UNLOCKED;
          end
        endcase
      end else if (cnt_sat) begin
        state   <= ST_UNLOCKED;
        locked  <= 1'b0;
        stalled <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_angle_tracker.sv
// -----------------------------------------------------------------------------
// tb_angle_tracker
//
// Directed bench for angle_tracker. It uses COUNTER_WIDTH=16, NB_ANGLES=8,
// MIN_PERIOD=64 and SYNC_STAGES=2.
//
// Inputs are driven on the falling edge, and outputs are sampled on the falling
// edge. Within a turn, j counts falling edges after the edge that processed the
// accepted tick, so j=0 is the cycle where turn_start is visible. A tick
// processed d edges later is produced by raising turn_tick at j=d-3 and
// lowering it at j=d-1. The first of those edges samples the new level, and the
// event lands two edges after that.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_angle_tracker;

  localparam int CW = 16;
  localparam int NB = 8;
  localparam int AW = 3;

  logic          clk;
  logic          nrst;
  logic          turn_tick;
  logic [AW-1:0] angle_offset;
  logic          reverse;
  logic [AW-1:0] angle;
  logic          angle_tick;
  logic          turn_start;
  logic [CW-1:0] period;
  logic          locked;
  logic          stalled;

  int checks   = 0;
  int failures = 0;

  angle_tracker #(
    .COUNTER_WIDTH (CW),
    .NB_ANGLES     (NB),
    .MIN_PERIOD    (64),
    .SYNC_STAGES   (2)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .turn_tick    (turn_tick),
    .angle_offset (angle_offset),
    .reverse      (reverse),
    .angle        (angle),
    .angle_tick   (angle_tick),
    .turn_start   (turn_start),
    .period       (period),
    .locked       (locked),
    .stalled      (stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output angle for raw slot r, using the bench's own
  // reverse/offset settings.
  function automatic logic [AW-1:0] exp_angle(input int r);
    int v;
    v = reverse ? (NB - 1 - r) : r;
    v = (v + int'(angle_offset)) % NB;
    return AW'(v);
  endfunction

  // Raise turn_tick so that the event is processed two edges later. Returns at
  // j=0 of the new turn.
  task automatic start_tick();
    turn_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    turn_tick = 1'b0;
    @(negedge clk);
  endtask

  // Step through one turn from j0 to d-1 and end with a tick processed at
  // j=d. slot=0 means the raw angle is held at 0 (measuring). glitch_at >= 0
  // injects a short pulse that starts at that j. Three comparisons are made:
  // the angle sequence, the angle_tick count and the turn_start count.
  task automatic run_turn(input int d, input int slot, input int j0,
                          input int glitch_at, input string name);
    int            r;
    int            bad;
    int            first_j;
    logic [AW-1:0] first_got;
    logic [AW-1:0] first_exp;
    logic [AW-1:0] ea;
    int            n_at;
    int            n_ts;
    int            exp_at;
    int            exp_ts;
    bad = 0; first_j = -1; first_got = '0; first_exp = '0;
    n_at = 0; n_ts = 0;
    for (int j = j0; j < d; j++) begin
      if (slot == 0) r = 0;
      else           r = j / slot;
      if (r > NB - 1) r = NB - 1;
      ea = exp_angle(r);
      if (angle !== ea) begin
        if (bad == 0) begin
          first_j   = j;
          first_got = angle;
          first_exp = ea;
        end
        bad++;
      end
      if (angle_tick === 1'b1) n_at++;
      if (turn_start === 1'b1) n_ts++;
      if (j == d - 3)         turn_tick = 1'b1;
      if (j == d - 1)         turn_tick = 1'b0;
      if (j == glitch_at)     turn_tick = 1'b1;
      if (j == glitch_at + 2) turn_tick = 1'b0;
      @(negedge clk);
    end
    exp_ts = (j0 == 0) ? 1 : 0;
    exp_at = exp_ts;
    if (slot != 0) begin
      for (int k = 1; k < NB; k++) begin
        if (k * slot >= j0 && k * slot <= d - 1) exp_at++;
      end
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL %s angle_seq: j=%0d angle=%0d expected %0d (%0d bad cycles)",
               name, first_j, first_got, first_exp, bad);
    end
    checks++;
    if (n_at !== exp_at) begin
      failures++;
      $display("FAIL %s angle_tick_count: got %0d expected %0d", name, n_at, exp_at);
    end
    checks++;
    if (n_ts !== exp_ts) begin
      failures++;
      $display("FAIL %s turn_start_count: got %0d expected %0d", name, n_ts, exp_ts);
    end
  endtask

  // Reset: outputs are 0 while nrst is low, even with turn_tick toggling. On
  // release, the offset appears on the first edge.
  task automatic test_reset();
    nrst = 1'b0; turn_tick = 1'b0; reverse = 1'b0; angle_offset = 3'd5;
    for (int i = 0; i < 6; i++) begin
      turn_tick = ~turn_tick;
      @(negedge clk);
    end
    turn_tick = 1'b0;
    checks++;
    if ({angle, angle_tick, turn_start, period, locked, stalled} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: angle=%0d at=%0b ts=%0b period=%0d locked=%0b stalled=%0b expected all 0",
               angle, angle_tick, turn_start, period, locked, stalled);
    end
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (angle !== 3'd5) begin
      failures++;
      $display("FAIL reset_release_angle: got %0d expected 5", angle);
    end
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_locked: got %0b expected 0", locked);
    end
  endtask

  // Steady rotation: ticks every 800 cycles. Lock is reached after the second
  // tick, with 8 slots of 100 cycles.
  task automatic test_steady();
    angle_offset = 3'd0;
    start_tick();
    checks++;
    if (turn_start !== 1'b1 || angle_tick !== 1'b1) begin
      failures++;
      $display("FAIL first_tick_strobes: ts=%0b at=%0b expected 1 1", turn_start, angle_tick);
    end
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL first_tick_locked: got %0b expected 0", locked);
    end
    run_turn(800, 0, 0, -1, "measuring");
    checks++;
    if (period !== 16'd800 || locked !== 1'b1) begin
      failures++;
      $display("FAIL lock_after_2nd: period=%0d locked=%0b expected 800 1", period, locked);
    end
    run_turn(800, 100, 0, -1, "steady1");
    run_turn(800, 100, 0, -1, "steady2");
  endtask

  // Glitch: a pulse 30 cycles after an accepted tick is ignored.
  task automatic test_glitch();
    run_turn(800, 100, 0, 30, "glitch");
    checks++;
    if (period !== 16'd800) begin
      failures++;
      $display("FAIL glitch_period: got %0d expected 800", period);
    end
  endtask

  // Slowdown, where the angle holds at 7, and speed-up, where the angle jumps
  // from 5 to 0.
  task automatic test_speed();
    run_turn(1000, 100, 0, -1, "slow1000");
    checks++;
    if (period !== 16'd1000) begin
      failures++;
      $display("FAIL slow_period: got %0d expected 1000", period);
    end
    run_turn(800, 125, 0, -1, "back800");
    checks++;
    if (period !== 16'd800) begin
      failures++;
      $display("FAIL back_period: got %0d expected 800", period);
    end
    run_turn(600, 100, 0, -1, "fast600");
    checks++;
    if (period !== 16'd600 || angle !== 3'd0) begin
      failures++;
      $display("FAIL fast_jump: period=%0d angle=%0d expected 600 0", period, angle);
    end
    run_turn(600, 75, 0, -1, "steady600");
  endtask

  // Reverse with offset 3 gives the sequence 2,1,0,7,6,5,4,3. An asynchronous
  // reset mid-turn clears all outputs immediately.
  task automatic test_reverse();
    reverse = 1'b1; angle_offset = 3'd3;
    @(negedge clk);
    checks++;
    if (angle !== 3'd2 || angle_tick !== 1'b0) begin
      failures++;
      $display("FAIL rev_switch: angle=%0d at=%0b expected 2 0", angle, angle_tick);
    end
    run_turn(600, 75, 1, -1, "rev_partial");
    run_turn(600, 75, 0, -1, "rev_full");
    repeat (200) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({angle, angle_tick, turn_start, period, locked, stalled} !== '0) begin
      failures++;
      $display("FAIL async_reset: angle=%0d at=%0b ts=%0b period=%0d locked=%0b stalled=%0b expected all 0",
               angle, angle_tick, turn_start, period, locked, stalled);
    end
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (angle !== 3'd2 || locked !== 1'b0) begin
      failures++;
      $display("FAIL rev_reset_release: angle=%0d locked=%0b expected 2 0", angle, locked);
    end
  endtask

  // Relock after reset, then stall: stalled rises exactly 65535 cycles after
  // the last tick, and the next tick clears it and enters measuring.
  task automatic test_stall();
    start_tick();
    checks++;
    if (turn_start !== 1'b1 || locked !== 1'b0) begin
      failures++;
      $display("FAIL relock_first: ts=%0b locked=%0b expected 1 0", turn_start, locked);
    end
    run_turn(700, 0, 0, -1, "relock_measure");
    checks++;
    if (period !== 16'd700 || locked !== 1'b1) begin
      failures++;
      $display("FAIL relock_second: period=%0d locked=%0b expected 700 1", period, locked);
    end
    reverse = 1'b0;
    repeat (65534) @(negedge clk);
    checks++;
    if (stalled !== 1'b0 || locked !== 1'b1 || angle !== 3'd2) begin
      failures++;
      $display("FAIL pre_stall: stalled=%0b locked=%0b angle=%0d expected 0 1 2",
               stalled, locked, angle);
    end
    @(negedge clk);
    checks++;
    if (stalled !== 1'b1 || locked !== 1'b0 || angle !== 3'd3) begin
      failures++;
      $display("FAIL stall: stalled=%0b locked=%0b angle=%0d expected 1 0 3",
               stalled, locked, angle);
    end
    checks++;
    if (period !== 16'd700) begin
      failures++;
      $display("FAIL stall_period: got %0d expected 700", period);
    end
    start_tick();
    checks++;
    if (stalled !== 1'b0 || turn_start !== 1'b1 || locked !== 1'b0) begin
      failures++;
      $display("FAIL stall_recover: stalled=%0b ts=%0b locked=%0b expected 0 1 0",
               stalled, turn_start, locked);
    end
    run_turn(800, 0, 0, -1, "post_stall_measure");
    checks++;
    if (period !== 16'd800 || locked !== 1'b1) begin
      failures++;
      $display("FAIL post_stall_lock: period=%0d locked=%0b expected 800 1", period, locked);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_glitch();
    test_speed();
    test_reverse();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
